// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
// Shared definitions for the program loader: the session state encoding and
// the helper that derives the byte-lane count of an instruction word.
// Optional feature macro: CHECKSUM_EN (adds the CHK state).
// -----------------------------------------------------------------------------
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
`ifdef CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERR
    } state_e;

    // Number of bytes that make up one DATA_W-bit instruction word.
    function automatic int unsigned byte_lanes(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Assembles accepted bytes into DATA_W-bit words, most significant byte first.
// Ports:
//   Clock, Reset_n  - clock and asynchronous active-low reset
//   clear           - discard any partial word and restart at byte 0
//   in_valid        - byte offered by the stream
//   in_ready        - loader is willing to take a byte this cycle
//   in_data         - byte value
//   word            - assembled word (valid only while word_valid=1)
//   word_valid      - single-cycle pulse on the cycle the last byte is accepted
// -----------------------------------------------------------------------------
module byte_packer
    import prog_loader_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic              in_ready,
    input  logic [7:0]        in_data,
    output logic [DATA_W-1:0] word,
    output logic              word_valid
);

    localparam int unsigned LANES = byte_lanes(DATA_W);
    localparam int unsigned CNT_W = $clog2(LANES);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-9:0] sh_q, sh_d;
    logic [DATA_W-1:0] joined;
    logic              accept;
    logic              last;

    assign accept     = in_valid && in_ready;
    assign joined     = {sh_q, in_data};
    assign last       = (cnt_q == CNT_W'(LANES - 1));
    // The final byte goes straight to the output, so the word is presented
    // on the same cycle its last byte is accepted.
    assign word       = joined;
    assign word_valid = accept && last;

    // NOTE: every signal written in a combinational block gets a default
    // first, otherwise paths that skip an assignment infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (clear) begin
            cnt_d = '0;
            sh_d  = '0;
        end else if (accept) begin
            sh_d  = joined[DATA_W-9:0];
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its inputs.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Receives a program over a byte stream (header word N, then N payload words)
// and writes it into instruction memory, then releases the CPU.
// Optional feature macro: CHECKSUM_EN -- a trailing word must equal the XOR
// of all payload words before the CPU is released.
// Ports:
//   Clock, Reset_n               - clock and asynchronous active-low reset
//   start                        - pulse that begins a load session
//   in_valid, in_data, in_ready  - byte stream with valid/ready handshake
//   mem_we, mem_addr, mem_wdata  - instruction-memory write port
//   cpu_run, done, error         - CPU release and session status
// -----------------------------------------------------------------------------
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_run,
    output logic              done,
    output logic              error
);

    localparam int unsigned       DEPTH   = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);

    state_e            state_q, state_d;
    // One extra bit so the counter and N can both reach DEPTH.
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    logic              packer_clear;
    logic [DATA_W-1:0] word;
    logic              word_valid;

    byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .clear      (packer_clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        n_d          = n_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
`ifdef CHECKSUM_EN
        csum_d       = csum_q;
`endif
        packer_clear = 1'b0;
        in_ready     = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d      = HDR;
                    cnt_d        = '0;
                    packer_clear = 1'b1;
`ifdef CHECKSUM_EN
                    csum_d       = '0;
`endif
                end
            end
            HDR: begin
                in_ready = 1'b1;
                if (word_valid) begin
                    n_d     = word[ADDR_W:0];
                    state_d = (word == '0 || word > DEPTH_W) ? ERR : LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                // Registered write: the pulse lands the cycle after the
                // word's last byte is accepted.
                if (word_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q[ADDR_W-1:0];
                    mem_wdata_d = word;
                    cnt_d       = cnt_q + 1'b1;
`ifdef CHECKSUM_EN
                    csum_d      = csum_q ^ word;
`endif
                end
                // Leave only once the N-th write pulse is actually on the port.
                if (mem_we_q && cnt_q == n_q) begin
`ifdef CHECKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef CHECKSUM_EN
            CHK: begin
                in_ready = 1'b1;
                if (word_valid) begin
                    state_d = (word == csum_q) ? DONE : ERR;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = (state_q == DONE);
    assign cpu_run   = (state_q == DONE);
    assign error     = (state_q == ERR);

endmodule
